inverter_bist: RTL

Self-checking stimulus/response engine for single-input inverting cells such as the switch-level CMOS inverter. It drives the cell's input, waits a programmable settle time, samples the cell's output and compares it against the expected complement. It accumulates error and X/Z statistics and reports pass/fail. It sits on the opposite side of the cell's `a`/`y` interface from the cell itself and replaces hand-written `$monitor` benches in the mini-project flow.

---
 rtl/inverter_bist_pkg.sv | 19 +
 rtl/settle_timer.sv | 29 ++
 rtl/inverter_bist.sv | 102 ++++++++++
 3 files changed

// File: rtl/inverter_bist_pkg.sv
// Shared types and helpers for the inverter BIST engine and related mini-project BISTs.
package inverter_bist_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  // Case equality so an X/Z response never matches; synthesis treats it as plain equality.
  function automatic logic bit_ok(input logic y, input logic expected);
    return (y === expected);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter: load arms it for CYCLES cycles, expired flags the last one.
module settle_timer #(
  parameter int CYCLES = 2,
  localparam int W = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam int LOAD_VAL = (CYCLES > 0) ? CYCLES - 1 : 0;

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(LOAD_VAL);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/inverter_bist.sv
// Stimulus/response engine for single-input inverting cells: drives 0,1,0,1,...
// waits a settle time, checks the complement and accumulates error and X/Z statistics.
module inverter_bist
  import inverter_bist_pkg::*;
#(
  parameter int NUM_VECTORS   = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             xz_seen
);

  localparam int K_W = $clog2(NUM_VECTORS + 1);
  localparam logic [K_W-1:0]   LAST_K  = K_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [K_W-1:0]   k_q;
  logic             timer_load, timer_expired;
  logic             mismatch, is_xz, xz_nxt;
  logic [CNT_W-1:0] err_nxt;

  assign timer_load = (state_q == DRIVE);

  settle_timer #(.CYCLES(SETTLE_CYCLES)) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   state_d = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      SETTLE:  if (timer_expired) state_d = CHECK;
      CHECK:   state_d = (k_q == LAST_K) ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A response that equals neither 0 nor 1 is X or Z; this folds to 0 in synthesis.
  always_comb begin
    mismatch = !bit_ok(dut_y, ~dut_a);
    is_xz    = !bit_ok(dut_y, 1'b0) && !bit_ok(dut_y, 1'b1);
    xz_nxt   = xz_seen | is_xz;
    err_nxt  = err_cnt;
    if (mismatch && (err_cnt != CNT_MAX)) err_nxt = err_cnt + CNT_W'(1);
  end

  // NOTE: only control/result flops live here and all take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= '0;
      dut_a   <= 1'b0;
      err_cnt <= '0;
      xz_seen <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            k_q     <= '0;
            err_cnt <= '0;
            xz_seen <= 1'b0;
            pass    <= 1'b0;
          end
        end
        DRIVE: dut_a <= k_q[0];
        CHECK: begin
          err_cnt <= err_nxt;
          xz_seen <= xz_nxt;
          k_q     <= k_q + K_W'(1);
          // Resolved on the final check so the verdict is already valid while done is high.
          if (k_q == LAST_K) pass <= (err_nxt == '0) && !xz_nxt;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
